// File: rtl/seg_display_scheduler.sv
// Arbitrates one 4-digit hex display among NUM_REQ requesters: round-robin with a
// minimum hold time, optional preemption by requester 0, fully registered outputs.
module seg_display_scheduler #(
    parameter int unsigned    NUM_REQ     = 3,
    parameter int unsigned    HOLD_CYCLES = 50_000_000,
    parameter int unsigned    CNT_W       = 26,
    parameter int unsigned    PREEMPT     = 1,
    parameter logic [15:0]    IDLE_VALUE  = 16'h0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   data,
    output logic [NUM_REQ-1:0]      grant,
    output logic [1:0]              owner,
    output logic                    busy,
    output logic                    switch_evt,
    output logic [15:0]             digits
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [1:0]           r_owner;
    logic                 r_busy;
    logic                 r_switch;
    logic [15:0]          r_digits;
    logic [CNT_W-1:0]     r_cnt;
    logic [1:0]           r_rr_ptr;

    state_t               w_state_nxt;
    logic                 w_take;
    logic [1:0]           w_new_owner;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [1:0]           w_owner_nxt;
    logic                 w_busy_nxt;
    logic                 w_switch_nxt;
    logic [15:0]          w_digits_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [1:0]           w_rr_nxt;

    logic [3:0]           w_req4;
    logic [2:0]           w_inc3;
    logic [1:0]           w_owner_inc;
    logic [1:0]           w_start;
    logic                 w_found;
    logic [1:0]           w_win;
    logic                 w_hold_done;

    function automatic logic [15:0] sel_word(input logic [1:0] ix,
                                             input logic [16*NUM_REQ-1:0] d);
        logic [15:0] w;
        w = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ix == 2'(i)) w = d[16*i +: 16];
        end
        return w;
    endfunction

    assign w_req4      = 4'(req);
    assign w_hold_done = (r_cnt == HOLD_MAX);

    always_comb begin
        w_inc3      = {1'b0, r_owner} + 3'd1;
        w_owner_inc = (w_inc3 >= 3'(NUM_REQ)) ? 2'd0 : w_inc3[1:0];
    end

    // Round-robin scan; in OWN the current owner is skipped so only competitors win.
    always_comb begin
        logic [2:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_win   = '0;
        w_start = (r_state == OWN) ? w_owner_inc : r_rr_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_idx = {1'b0, w_start} + 3'(k);
            if (v_idx >= 3'(NUM_REQ)) v_idx = v_idx - 3'(NUM_REQ);
            if (!w_found && w_req4[v_idx[1:0]] &&
                !(r_state == OWN && v_idx[1:0] == r_owner)) begin
                w_found = 1'b1;
                w_win   = v_idx[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_busy   <= 1'b0;
            r_switch <= 1'b0;
            r_digits <= IDLE_VALUE;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_owner  <= w_owner_nxt;
            r_busy   <= w_busy_nxt;
            r_switch <= w_switch_nxt;
            r_digits <= w_digits_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Transition priority in OWN: release, then preemption by 0, then hold expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_new_owner = w_win;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_take      = 1'b1;
                    w_state_nxt = OWN;
                end
            end
            OWN: begin
                if (!w_req4[r_owner]) begin
                    if (w_found) w_take = 1'b1;
                    else         w_state_nxt = IDLE;
                end else if (PREEMPT != 0 && req[0] && r_owner != 2'd0) begin
                    w_take      = 1'b1;
                    w_new_owner = 2'd0;
                end else if (w_hold_done && w_found) begin
                    w_take = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_owner_nxt  = r_owner;
        w_busy_nxt   = r_busy;
        w_switch_nxt = 1'b0;
        w_digits_nxt = r_digits;
        w_cnt_nxt    = r_cnt;
        w_rr_nxt     = r_rr_ptr;
        if (w_take) begin
            w_owner_nxt  = w_new_owner;
            w_busy_nxt   = 1'b1;
            w_switch_nxt = 1'b1;
            w_digits_nxt = sel_word(w_new_owner, data);
            w_cnt_nxt    = '0;
        end else if (w_state_nxt == IDLE) begin
            w_owner_nxt  = '0;
            w_busy_nxt   = 1'b0;
            w_switch_nxt = (r_state == OWN);
            w_digits_nxt = IDLE_VALUE;
            w_cnt_nxt    = '0;
            if (r_state == OWN) w_rr_nxt = w_owner_inc;
        end else begin
            w_digits_nxt = sel_word(r_owner, data);
            if (!w_hold_done) w_cnt_nxt = r_cnt + 1'b1;
        end
        w_grant_nxt = w_busy_nxt ? (NUM_REQ'(1) << w_owner_nxt) : '0;
    end

    assign grant      = r_grant;
    assign owner      = r_owner;
    assign busy       = r_busy;
    assign switch_evt = r_switch;
    assign digits     = r_digits;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler: per-cycle vector table plus hand-written
// asynchronous reset sequence; HOLD_CYCLES=4, NUM_REQ=3, PREEMPT=1.
module tb_seg_display_scheduler;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [47:0] data;
    logic [2:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic        switch_evt;
    logic [15:0] digits;
    logic [15:0] d1;

    int n_err;
    int n_checks;

    typedef struct {
        logic [2:0]  req;
        logic [15:0] d1;
        logic [2:0]  g;
        logic [1:0]  o;
        logic        b;
        logic        sw;
        logic [15:0] dig;
    } vec_t;

    vec_t tbl [25];

    seg_display_scheduler #(
        .NUM_REQ     (3),
        .HOLD_CYCLES (4),
        .CNT_W       (3),
        .PREEMPT     (1),
        .IDLE_VALUE  (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data       (data),
        .grant      (grant),
        .owner      (owner),
        .busy       (busy),
        .switch_evt (switch_evt),
        .digits     (digits)
    );

    assign data = {16'h2222, d1, 16'h0000};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic check_all(input int row, input logic [2:0] g, input logic [1:0] o,
                             input logic b, input logic sw, input logic [15:0] dig);
        chk("grant", row, 16'(grant), 16'(g));
        chk("busy", row, 16'(busy), 16'(b));
        chk("switch_evt", row, 16'(switch_evt), 16'(sw));
        chk("digits", row, digits, dig);
        if (b) chk("owner", row, 16'(owner), 16'(o));
    endtask

    task automatic step(input logic [2:0] r, input logic [15:0] dv);
        req = r;
        d1  = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_err    = 0;
        n_checks = 0;
        reset    = 1'b1;
        req      = 3'b000;
        d1       = 16'h1111;

        tbl[0]  = '{3'b000, 16'h1111, 3'b000, 2'd0, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{3'b000, 16'h1111, 3'b000, 2'd0, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{3'b000, 16'h1111, 3'b000, 2'd0, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{3'b010, 16'h1111, 3'b010, 2'd1, 1'b1, 1'b1, 16'h1111};
        tbl[4]  = '{3'b010, 16'hBEEF, 3'b010, 2'd1, 1'b1, 1'b0, 16'hBEEF};
        tbl[5]  = '{3'b010, 16'h1111, 3'b010, 2'd1, 1'b1, 1'b0, 16'h1111};
        tbl[6]  = '{3'b110, 16'h1111, 3'b010, 2'd1, 1'b1, 1'b0, 16'h1111};
        tbl[7]  = '{3'b110, 16'h1111, 3'b100, 2'd2, 1'b1, 1'b1, 16'h2222};
        tbl[8]  = '{3'b110, 16'h1111, 3'b100, 2'd2, 1'b1, 1'b0, 16'h2222};
        tbl[9]  = '{3'b110, 16'h1111, 3'b100, 2'd2, 1'b1, 1'b0, 16'h2222};
        tbl[10] = '{3'b110, 16'h1111, 3'b100, 2'd2, 1'b1, 1'b0, 16'h2222};
        tbl[11] = '{3'b110, 16'h1111, 3'b010, 2'd1, 1'b1, 1'b1, 16'h1111};
        tbl[12] = '{3'b010, 16'h1111, 3'b010, 2'd1, 1'b1, 1'b0, 16'h1111};
        tbl[13] = '{3'b000, 16'h1111, 3'b000, 2'd0, 1'b0, 1'b1, 16'h0000};
        tbl[14] = '{3'b011, 16'h1111, 3'b001, 2'd0, 1'b1, 1'b1, 16'h0000};
        tbl[15] = '{3'b100, 16'h1111, 3'b100, 2'd2, 1'b1, 1'b1, 16'h2222};
        tbl[16] = '{3'b100, 16'h1111, 3'b100, 2'd2, 1'b1, 1'b0, 16'h2222};
        tbl[17] = '{3'b101, 16'h1111, 3'b001, 2'd0, 1'b1, 1'b1, 16'h0000};
        tbl[18] = '{3'b100, 16'h1111, 3'b100, 2'd2, 1'b1, 1'b1, 16'h2222};
        tbl[19] = '{3'b100, 16'h1111, 3'b100, 2'd2, 1'b1, 1'b0, 16'h2222};
        tbl[20] = '{3'b100, 16'h1111, 3'b100, 2'd2, 1'b1, 1'b0, 16'h2222};
        tbl[21] = '{3'b100, 16'h1111, 3'b100, 2'd2, 1'b1, 1'b0, 16'h2222};
        tbl[22] = '{3'b100, 16'h1111, 3'b100, 2'd2, 1'b1, 1'b0, 16'h2222};
        tbl[23] = '{3'b110, 16'h1111, 3'b010, 2'd1, 1'b1, 1'b1, 16'h1111};
        tbl[24] = '{3'b010, 16'h1111, 3'b010, 2'd1, 1'b1, 1'b0, 16'h1111};

        repeat (2) @(posedge clk);
        #1;
        check_all(-1, 3'b000, 2'd0, 1'b0, 1'b0, 16'h0000);
        chk("owner_rst", -1, 16'(owner), 16'h0000);
        #2 reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].req, tbl[i].d1);
            check_all(i, tbl[i].g, tbl[i].o, tbl[i].b, tbl[i].sw, tbl[i].dig);
        end

        // Move ownership to 2, then hit reset asynchronously mid-hold.
        step(3'b100, 16'h1111);
        check_all(100, 3'b100, 2'd2, 1'b1, 1'b1, 16'h2222);
        step(3'b100, 16'h1111);
        check_all(101, 3'b100, 2'd2, 1'b1, 1'b0, 16'h2222);
        #2 reset = 1'b1;
        #1;
        check_all(102, 3'b000, 2'd0, 1'b0, 1'b0, 16'h0000);
        chk("owner_async_rst", 102, 16'(owner), 16'h0000);
        @(posedge clk);
        #1;
        check_all(103, 3'b000, 2'd0, 1'b0, 1'b0, 16'h0000);
        #2 reset = 1'b0;
        step(3'b100, 16'h1111);
        check_all(104, 3'b100, 2'd2, 1'b1, 1'b1, 16'h2222);
        step(3'b100, 16'h1111);
        check_all(105, 3'b100, 2'd2, 1'b1, 1'b0, 16'h2222);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
